// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared types and constants for the USB receive path
package usb_pkg;

  typedef enum logic [1:0] {J, K, SE0, SE1} line_state_t;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERROR} rx_state_t;

  // SYNC pattern in wire order, bit 0 arrives first
  localparam logic [7:0]  SYNC_BITS      = 8'b1000_0000;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  function automatic line_state_t decode_line(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return J;
      2'b01:   return K;
      2'b00:   return SE0;
      default: return SE1;
    endcase
  endfunction

endpackage

// File: rtl/usb_rx_nrzi_unstuff.sv
// rtl/usb_rx_nrzi_unstuff.sv - line decode, NRZI decode and stuffed-bit removal
module usb_rx_nrzi_unstuff
  import usb_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic dp,
  input  logic dm,
  input  logic i_ones_load,
  input  logic i_ones_en,
  output logic o_bit,
  output logic o_bit_valid,
  output logic o_stuff_err,
  output logic o_stuff_pending,
  output logic o_j,
  output logic o_k,
  output logic o_se0,
  output logic o_se1
);

  line_state_t r_prev_line;
  logic [2:0]  r_ones_cnt;
  line_state_t w_line;
  logic        w_jk;
  logic        w_at_six;

  assign w_line          = decode_line(dp, dm);
  assign o_j             = (w_line == J);
  assign o_k             = (w_line == K);
  assign o_se0           = (w_line == SE0);
  assign o_se1           = (w_line == SE1);
  assign w_jk            = o_j || o_k;
  assign o_bit           = (w_line == r_prev_line);
  assign w_at_six        = (r_ones_cnt == 3'd6);
  assign o_stuff_pending = w_at_six;
  // after six ones the next bit is a stuffed zero and never reaches the byte
  assign o_bit_valid     = w_jk && !(i_ones_en && w_at_six);
  assign o_stuff_err     = w_jk && i_ones_en && w_at_six && o_bit;

  // track previous J/K level and the run of consecutive decoded ones
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_line <= J;
      r_ones_cnt  <= 3'd0;
    end else begin
      if (w_jk) r_prev_line <= w_line;
      if (i_ones_load) begin
        r_ones_cnt <= 3'd1;
      end else if (i_ones_en && w_jk) begin
        if (w_at_six || !o_bit) r_ones_cnt <= 3'd0;
        else                    r_ones_cnt <= r_ones_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/usb_rx_deserializer.sv
// rtl/usb_rx_deserializer.sv - USB RX: SYNC detect, unstuff, byte assembly, framing; CRC16 check with USB_RX_CRC16_CHECK_EN
module usb_rx_deserializer
  import usb_pkg::*;
#(
  parameter int MAX_BYTES     = 67,
  parameter int IDLE_J_CYCLES = 8
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           dp,
  input  logic                           dm,
  input  logic                           rx_enable,
  output logic [7:0]                     byte_out,
  output logic                           byte_valid,
  output logic                           pkt_start,
  output logic                           pkt_end,
  output logic                           pkt_error,
  output logic [$clog2(MAX_BYTES+1)-1:0] byte_cnt,
  output logic                           crc16_ok
);

  localparam int            CW      = $clog2(MAX_BYTES + 1);
  localparam int            JW      = $clog2(IDLE_J_CYCLES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);
  localparam logic [JW-1:0] J_LAST  = JW'(IDLE_J_CYCLES - 1);

  rx_state_t     r_state;
  logic [2:0]    r_sync_idx;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_sipo;
  logic [7:0]    r_byte_out;
  logic [1:0]    r_se0_cnt;
  logic [JW-1:0] r_j_cnt;
  logic [CW-1:0] r_byte_cnt;
  logic          r_byte_valid, r_pkt_start, r_pkt_end, r_pkt_error;

  logic w_bit, w_bit_valid, w_stuff_err, w_stuff_pending;
  logic w_j, w_k, w_se0, w_se1, w_jk, w_in_data;
  logic w_sync_bit_ok, w_sync_done, w_data_bit, w_end, w_fail;

  usb_rx_nrzi_unstuff u_nrzi (
    .clock           (clock),
    .reset_n         (reset_n),
    .dp              (dp),
    .dm              (dm),
    .i_ones_load     (w_sync_done),
    .i_ones_en       (w_in_data),
    .o_bit           (w_bit),
    .o_bit_valid     (w_bit_valid),
    .o_stuff_err     (w_stuff_err),
    .o_stuff_pending (w_stuff_pending),
    .o_j             (w_j),
    .o_k             (w_k),
    .o_se0           (w_se0),
    .o_se1           (w_se1)
  );

  assign w_jk          = w_j || w_k;
  assign w_in_data     = (r_state == DATA);
  assign w_sync_bit_ok = w_jk && (w_bit == SYNC_BITS[r_sync_idx]);
  assign w_sync_done   = (r_state == SYNC) && rx_enable && w_sync_bit_ok && (r_sync_idx == 3'd7);
  assign w_data_bit    = w_in_data && !w_fail && w_bit_valid;
  assign w_end         = (r_state == EOP) && !w_fail && w_j;

  // every condition that aborts a packet into ERROR
  always_comb begin
    w_fail = 1'b0;
    case (r_state)
      SYNC: w_fail = !rx_enable;
      DATA: w_fail = !rx_enable || w_se1 || w_stuff_err ||
                     (w_bit_valid && (r_bit_idx == 3'd7) && (r_byte_cnt == MAX_CNT));
      EOP:  w_fail = !rx_enable || w_se1 || w_k ||
                     (w_se0 && (r_se0_cnt == 2'd2)) ||
                     (w_j && !((r_se0_cnt == 2'd2) && (r_bit_idx == 3'd0) && !w_stuff_pending));
      default: w_fail = 1'b0;
    endcase
  end

  // receive FSM with registered strobes, byte assembly and byte counting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_sync_idx   <= 3'd0;
      r_bit_idx    <= 3'd0;
      r_sipo       <= 8'd0;
      r_byte_out   <= 8'd0;
      r_se0_cnt    <= 2'd0;
      r_j_cnt      <= '0;
      r_byte_cnt   <= '0;
      r_byte_valid <= 1'b0;
      r_pkt_start  <= 1'b0;
      r_pkt_end    <= 1'b0;
      r_pkt_error  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_pkt_start  <= 1'b0;
      r_pkt_end    <= 1'b0;
      r_pkt_error  <= 1'b0;
      if (w_fail) begin
        r_state     <= ERROR;
        r_pkt_error <= 1'b1;
        r_j_cnt     <= '0;
        r_se0_cnt   <= 2'd0;
      end else begin
        case (r_state)
          IDLE: begin
            if (rx_enable && w_k) begin
              r_state    <= SYNC;
              r_sync_idx <= 3'd1;
            end
          end
          SYNC: begin
            if (w_sync_done) begin
              r_state     <= DATA;
              r_pkt_start <= 1'b1;
              r_byte_cnt  <= '0;
              r_bit_idx   <= 3'd0;
            end else if (w_sync_bit_ok) begin
              r_sync_idx <= r_sync_idx + 3'd1;
            end else begin
              r_state <= IDLE;
            end
          end
          DATA: begin
            if (w_se0) begin
              r_state   <= EOP;
              r_se0_cnt <= 2'd1;
            end else if (w_data_bit) begin
              r_sipo    <= {w_bit, r_sipo[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
                r_byte_out   <= {w_bit, r_sipo[7:1]};
                r_byte_valid <= 1'b1;
                r_byte_cnt   <= r_byte_cnt + CW'(1);
              end
            end
          end
          EOP: begin
            if (w_se0) begin
              r_se0_cnt <= 2'd2;
            end else if (w_end) begin
              r_pkt_end <= 1'b1;
              r_state   <= IDLE;
            end
          end
          ERROR: begin
            if (w_j) begin
              if ((r_se0_cnt == 2'd2) || (r_j_cnt == J_LAST)) r_state <= IDLE;
              r_j_cnt   <= r_j_cnt + JW'(1);
              r_se0_cnt <= 2'd0;
            end else if (w_se0) begin
              r_j_cnt <= '0;
              if (r_se0_cnt != 2'd2) r_se0_cnt <= r_se0_cnt + 2'd1;
            end else begin
              r_j_cnt   <= '0;
              r_se0_cnt <= 2'd0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign pkt_start  = r_pkt_start;
  assign pkt_end    = r_pkt_end;
  assign pkt_error  = r_pkt_error;
  assign byte_cnt   = r_byte_cnt;

`ifdef USB_RX_CRC16_CHECK_EN
  logic [15:0] r_crc;
  logic        r_crc16_ok;
  logic        w_fb;

  assign w_fb = w_bit ^ r_crc[15];

  // serial CRC16 over every data bit after the PID byte, judged at clean EOP
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_crc      <= CRC16_INIT;
      r_crc16_ok <= 1'b0;
    end else if (w_sync_done) begin
      r_crc      <= CRC16_INIT;
      r_crc16_ok <= 1'b0;
    end else begin
      if (w_data_bit && (r_byte_cnt != '0))
        r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
      if (w_end) r_crc16_ok <= (r_crc == CRC16_RESIDUAL);
    end
  end

  assign crc16_ok = r_crc16_ok;
`else
  assign crc16_ok = 1'b0;
`endif

endmodule

// File: doc/usb_rx_deserializer.md
Name: usb_rx_deserializer

Overview:
- Receive-side counterpart of the transmit serializer path: samples the differential USB line once per bit-time `clock`, NRZI-decodes it, detects SYNC, removes stuffed bits, and assembles LSB-first bytes.
- Reports packet framing (start, end, error) to the protocol FSM, which consumes one byte per `byte_valid` pulse.
- Sits between the line pins (after synchronizers) and the packet-level receive handler.

Parameters:
- MAX_BYTES, 67, maximum bytes per packet (PID + 64 data + 2 CRC); exceeding it is an error.
- IDLE_J_CYCLES, 8, consecutive J cycles that return ERROR to IDLE.

Ports:
- clock  input  1  bit-rate clock
- reset_n  input  1  asynchronous, active-low reset
- dp  input  1  synchronized D+
- dm  input  1  synchronized D-
- rx_enable  input  1  receive permitted
- byte_out  output  8  assembled byte, LSB first on the wire
- byte_valid  output  1  one-cycle strobe, byte_out valid
- pkt_start  output  1  one-cycle strobe, SYNC accepted
- pkt_end  output  1  one-cycle strobe, clean EOP on a byte boundary
- pkt_error  output  1  one-cycle strobe, packet aborted
- byte_cnt  output  $clog2(MAX_BYTES+1)  bytes received in current packet
- crc16_ok  output  1  CRC16 residual check result, valid with pkt_end

Behaviour:
- Clock and reset: clock `clock`; reset `reset_n`, asynchronous, active-low. Reset clears all outputs to 0, sets prev_line = J, state = IDLE and ones_cnt = 0. Reset mid-packet drops the packet with no strobes.
- Line decode: J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1). NRZI: bit = 1 if line equals prev_line, else 0. prev_line updates on every J/K cycle.
- States:
  - IDLE: on first K with rx_enable = 1, go to SYNC (that K decodes as bit 0).
  - SYNC: expects decoded bits 0,0,0,0,0,0,0,1.
    - On a mismatch, or a non-J/K line, return to IDLE silently.
    - On the final 1: pulse pkt_start, set ones_cnt = 1, byte_cnt = 0, bit_idx = 0, go to DATA.
  - DATA: for each J/K cycle:
    - If ones_cnt == 6: a decoded 0 is discarded and ones_cnt = 0; a decoded 1 is a stuff error.
    - Otherwise: shift the bit into the SIPO right (LSB first), bit_idx += 1, ones_cnt = bit ? ones_cnt+1 : 0.
    - When bit_idx reaches 8: on the next cycle, byte_out = assembled byte, byte_valid = 1, byte_cnt += 1, bit_idx = 0.
    - SE0 goes to EOP.
  - EOP: a second SE0 must follow, then J.
    - SE0,SE0,J with bit_idx == 0 and no pending stuff bit: pulse pkt_end in the J cycle, go to IDLE.
    - Otherwise (SE0 only once, third SE0, K, or bit_idx != 0): pkt_error.
  - ERROR: pkt_error pulses on entry. Return to IDLE after IDLE_J_CYCLES consecutive J, or after an SE0,SE0,J sequence. No byte_valid while in ERROR.
- Error causes: stuff error, SE1 in DATA or EOP, misaligned EOP, byte_cnt would exceed MAX_BYTES, rx_enable deasserted in SYNC, DATA or EOP. All go to ERROR with one pkt_error pulse.
- Simultaneous events: byte_valid for the 8th bit and an SE0 in the same cycle are both legal; that byte counts.
- Other output rules:
  - byte_cnt holds its value after pkt_end/pkt_error until the next pkt_start.
  - byte_out holds its value between strobes.

Optional Feature:
- Macro: USB_RX_CRC16_CHECK_EN.
- Defined: a serial CRC16 (poly 0x8005, init 0xFFFF) runs on all data bits after the first byte (PID).
  - At pkt_end, crc16_ok = 1 iff the register equals residual 0x800D.
  - crc16_ok is held until the next pkt_start.
  - A bad CRC does not raise pkt_error.
- Undefined: no CRC logic; crc16_ok tied to 0.

Decomposition:
- Package usb_pkg: line_state_t enum {J, K, SE0, SE1}; rx_state_t enum {IDLE, SYNC, DATA, EOP, ERROR}; SYNC_BITS = 8'b1000_0000 (LSB-first order); CRC16_POLY = 16'h8005; CRC16_INIT = 16'hFFFF; CRC16_RESIDUAL = 16'h800D.
- Sub-module usb_rx_nrzi_unstuff: line decode, NRZI, ones counter. Outputs bit, bit_valid (0 for stuffed bits), stuff_err, se0, se1.
- Byte assembly reuses the existing right-shifting SIPO register.

Test Plan:
- ACK packet: SYNC, PID 0xD2, SE0,SE0,J -> pkt_start; one byte_valid with byte_out = 0xD2; pkt_end; byte_cnt = 1; pkt_error never.
- Stuffing: DATA0 0xC3, bytes 0xFF, 0x00 with a stuffed 0 after the 6th 1 -> bytes 0xC3, 0xFF, 0x00; byte_cnt = 3; pkt_end.
- Stuff error: seven consecutive 1s in DATA -> one pkt_error, no pkt_end; IDLE after 8 J cycles; next ACK received cleanly.
- Misaligned EOP: PID 0xD2 then 5 bits then SE0,SE0,J -> pkt_error, no pkt_end.
- Also: a single SE0 followed by K -> pkt_error.
- CRC (macro on): zero-length DATA0 (0xC3, 0x00, 0x00) -> pkt_end, crc16_ok = 1. Payload 0x01 with CRC bytes 0x00, 0x00 -> pkt_end, crc16_ok = 0.
- Abort: rx_enable = 0 mid-byte -> pkt_error.
- Reset: reset_n low mid-packet -> all outputs 0 immediately; next packet received normally.
